o_delay_tap_ctrl: RTL and testbench
===================================

// Module: o_delay_tap_ctrl
// PURPOSE
//  Control stage that sits directly upstream of the O_DELAY primitive. It owns O_DELAY's
//  DLY_LOAD, DLY_ADJ and DLY_INCDEC inputs and reads back DLY_TAP_VALUE.
//  It turns a single request into a paced sequence of one-cycle DLY_ADJ pulses:
//  "go to tap N", or "reload the DELAY parameter".
//  After every pulse it waits for the tap to settle, then checks the tap readback.
//  It signals completion (DONE) or non-convergence (ERR).
// PARAMETERS
//  SETTLE_CYCLES  4   idle cycles after each DLY_ADJ/DLY_LOAD pulse before readback; legal 2..15, else $fatal
//  MAX_STEPS      64  DLY_ADJ pulses allowed per request before ERR; legal 1..127, else $fatal
// PORTS
//  CLK_IN         in   1  clock, shared with O_DELAY.CLK_IN
//  RST            in   1  reset: asynchronous, active-low
//  TARGET_TAP     in   6  requested tap value, 0..63
//  TARGET_VALID   in   1  move request; accepted only while BUSY=0
//  LOAD_REQ       in   1  reload request; accepted only while BUSY=0; wins over TARGET_VALID if both are high
//  BUSY           out  1  high from the accepting edge until DONE/ERR
//  DONE           out  1  one-cycle pulse when a request completes successfully
//  ERR            out  1  sticky; cleared when the next request is accepted
//  STEP_COUNT     out  7  DLY_ADJ pulses issued for the current/last request
//  DLY_LOAD       out  1  drives O_DELAY.DLY_LOAD
//  DLY_ADJ        out  1  drives O_DELAY.DLY_ADJ
//  DLY_INCDEC     out  1  drives O_DELAY.DLY_INCDEC; 1 = increment
//  DLY_TAP_VALUE  in   6  readback from O_DELAY.DLY_TAP_VALUE
// BEHAVIOUR
//  Reset: every output is 0 and the FSM is in IDLE. The target register and the settle counter are cleared.
//   - Reset is asynchronous and takes effect immediately, including mid-sequence.
//   - Reset does not restore O_DELAY's tap. O_DELAY has no reset, so its tap holds its last value.
//  All outputs are registered; DLY_* outputs are glitch-free.
//  States: IDLE, CHECK, ADJ, WAIT, LOAD, LWAIT.
//  IDLE:
//   - LOAD_REQ=1 -> LOAD.
//   - Else TARGET_VALID=1 -> latch TARGET_TAP, then CHECK.
//   - On either accept: clear ERR and STEP_COUNT, and set BUSY.
//  CHECK (one cycle): compare DLY_TAP_VALUE with the latched target.
//   - Equal -> IDLE, with DONE=1 and BUSY=0 on the next cycle.
//   - Not equal and STEP_COUNT==MAX_STEPS -> IDLE, with ERR=1 and BUSY=0. No DONE.
//   - Otherwise -> ADJ, with DLY_INCDEC = (target > DLY_TAP_VALUE).
//  ADJ (one cycle):
//   - DLY_ADJ=1 for exactly this cycle; STEP_COUNT increments.
//   - Then WAIT, with the settle counter loaded to SETTLE_CYCLES.
//  WAIT: count down SETTLE_CYCLES cycles, then CHECK.
//  DLY_INCDEC changes only on the transition CHECK->ADJ. It is held through ADJ and WAIT,
//   so it is stable when O_DELAY samples it two edges after DLY_ADJ rises.
//  DLY_ADJ is never high on two consecutive cycles. Low gap >= SETTLE_CYCLES+1 >= 3 cycles,
//   which guarantees every pulse is seen as a fresh rising edge.
//  LOAD: DLY_LOAD=1 for one cycle, then LWAIT for SETTLE_CYCLES cycles.
//   - LWAIT exits to IDLE with DONE=1. No tap check; STEP_COUNT stays 0.
//  Latency, counted in edges from the accepting edge to the edge that raises DONE:
//   - move needing N steps: 1 + N*(SETTLE_CYCLES+2); N=0 gives 1 edge.
//   - load: 1 + SETTLE_CYCLES.
//  Requests arriving while BUSY=1 are ignored, with no queueing.
//  TARGET_TAP changes after the accepting edge have no effect.
//  Tap boundaries 0 and 63 need no special handling: direction always points toward the target.
//   If O_DELAY ever saturates or stalls, the MAX_STEPS guard ends the request with ERR.
//  DONE and ERR are never high in the same cycle.
// TESTING
//  1 Reset release, with no requests -> all outputs 0 and BUSY=0 for 20 cycles; DLY_* stay low.
//  2 Tap=0, TARGET_TAP=5 with SETTLE_CYCLES=4 ->
//     five DLY_ADJ pulses with DLY_INCDEC=1; DONE 31 edges after accept; STEP_COUNT=5; tap=5.
//  3 Tap=40, TARGET_TAP=38 -> two pulses with DLY_INCDEC=0; DONE after 13 edges; tap=38.
//  4 Tap=12, TARGET_TAP=12 -> no DLY_ADJ pulse; DONE one edge after accept; STEP_COUNT=0.
//  5 LOAD_REQ and TARGET_VALID high together, with DELAY=20 ->
//     one DLY_LOAD pulse; DONE after 5 edges; tap=20; TARGET_VALID ignored.
//  6 O_DELAY model stubbed so the tap never moves, MAX_STEPS=3 -> three pulses, then ERR=1 with no DONE.
//     A later valid request clears ERR.
//     A separate run of case 2 with RST asserted after pulse 2 -> all outputs 0 at once; tap holds 2.

Source files
------------

// File: rtl/o_delay_tap_ctrl.sv
// rtl/o_delay_tap_ctrl.sv - paced DLY_ADJ/DLY_LOAD sequencer with tap readback for O_DELAY
module o_delay_tap_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_STEPS     = 64
) (
  input  logic       clk_in_i,
  input  logic       rst_n_i,
  input  logic [5:0] target_tap_i,
  input  logic       target_valid_i,
  input  logic       load_req_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [6:0] step_count_o,
  output logic       dly_load_o,
  output logic       dly_adj_o,
  output logic       dly_incdec_o,
  input  logic [5:0] dly_tap_value_i
);

  // Out-of-range settle time would break the pulse spacing; out-of-range step
  // limit would not fit the step counter.
  generate
    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $fatal(1, "o_delay_tap_ctrl: SETTLE_CYCLES must be 2..15");
    end
    if (MAX_STEPS < 1 || MAX_STEPS > 127) begin : g_bad_steps
      $fatal(1, "o_delay_tap_ctrl: MAX_STEPS must be 1..127");
    end
  endgenerate

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [6:0] STEP_LIMIT  = 7'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADJ   = 3'd2,
    S_WAIT  = 3'd3,
    S_LOAD  = 3'd4,
    S_LWAIT = 3'd5
  } state_t;

  state_t     state_q;
  logic [5:0] target_q;
  logic [3:0] settle_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic [6:0] step_count_q;
  logic       dly_load_q;
  logic       dly_adj_q;
  logic       dly_incdec_q;

  // Sequencer: every output is a flop so the O_DELAY control pins never glitch.
  // DLY_ADJ/DLY_LOAD/DONE default low each cycle, which makes them single-cycle pulses.
  always_ff @(posedge clk_in_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      step_count_q <= '0;
      dly_load_q   <= 1'b0;
      dly_adj_q    <= 1'b0;
      dly_incdec_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      dly_adj_q  <= 1'b0;
      dly_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_req_i) begin
            state_q      <= S_LOAD;
            dly_load_q   <= 1'b1;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            step_count_q <= '0;
          end else if (target_valid_i) begin
            state_q      <= S_CHECK;
            target_q     <= target_tap_i;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            step_count_q <= '0;
          end
        end
        S_CHECK: begin
          if (dly_tap_value_i == target_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (step_count_q == STEP_LIMIT) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            // Direction is fixed here and held through ADJ and WAIT so it is
            // stable when O_DELAY samples it after the pulse edge.
            state_q      <= S_ADJ;
            dly_incdec_q <= (target_q > dly_tap_value_i);
            dly_adj_q    <= 1'b1;
            step_count_q <= step_count_q + 7'd1;
          end
        end
        S_ADJ: begin
          state_q  <= S_WAIT;
          settle_q <= SETTLE_INIT;
        end
        S_WAIT: begin
          if (settle_q == 4'd1) begin
            state_q  <= S_CHECK;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        S_LOAD: begin
          state_q  <= S_LWAIT;
          settle_q <= SETTLE_INIT;
        end
        S_LWAIT: begin
          if (settle_q == 4'd1) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign step_count_o = step_count_q;
  assign dly_load_o   = dly_load_q;
  assign dly_adj_o    = dly_adj_q;
  assign dly_incdec_o = dly_incdec_q;

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// tb/tb_o_delay_tap_ctrl.sv - scoreboard bench for o_delay_tap_ctrl with a behavioural O_DELAY
module tb_o_delay_tap_ctrl;

  localparam int         SETTLE = 4;
  localparam logic [5:0] DELAY  = 6'd20;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT with default step limit
  logic [5:0] target_tap = '0;
  logic       target_valid = 1'b0;
  logic       load_req = 1'b0;
  logic       busy, done, err, dly_load, dly_adj, dly_incdec;
  logic [6:0] step_count;
  logic [5:0] tap = '0;

  o_delay_tap_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_STEPS(64)) dut (
    .clk_in_i(clk), .rst_n_i(rst_n), .target_tap_i(target_tap),
    .target_valid_i(target_valid), .load_req_i(load_req), .busy_o(busy),
    .done_o(done), .err_o(err), .step_count_o(step_count), .dly_load_o(dly_load),
    .dly_adj_o(dly_adj), .dly_incdec_o(dly_incdec), .dly_tap_value_i(tap)
  );

  // Second DUT against a stuck tap with a tiny step limit
  logic [5:0] t2_tap = '0;
  logic       t2_valid = 1'b0;
  logic       busy2, done2, err2, load2, adj2, incdec2;
  logic [6:0] step2;
  logic [5:0] stuck_tap = 6'd10;

  o_delay_tap_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_STEPS(3)) dut_err (
    .clk_in_i(clk), .rst_n_i(rst_n), .target_tap_i(t2_tap),
    .target_valid_i(t2_valid), .load_req_i(1'b0), .busy_o(busy2),
    .done_o(done2), .err_o(err2), .step_count_o(step2), .dly_load_o(load2),
    .dly_adj_o(adj2), .dly_incdec_o(incdec2), .dly_tap_value_i(stuck_tap)
  );

  // O_DELAY model: no reset; a DLY_ADJ rising edge is seen one edge later and
  // the tap moves on the following edge using the held DLY_INCDEC.
  logic       adj_seen = 1'b0;
  logic       pend = 1'b0;
  logic       set_req = 1'b0;
  logic [5:0] set_val = '0;
  always @(posedge clk) begin
    pend     <= dly_adj && !adj_seen;
    adj_seen <= dly_adj;
    if (set_req) tap <= set_val;
    else if (dly_load) tap <= DELAY;
    else if (pend) begin
      if (dly_incdec) begin
        if (tap != 6'd63) tap <= tap + 6'd1;
      end else if (tap != 6'd0) tap <= tap - 6'd1;
    end
  end

  // Free-running event totals; tests take deltas
  int up_tot = 0, dn_tot = 0, load_tot = 0, b2b_tot = 0, dual_tot = 0;
  int adj2_tot = 0, done2_tot = 0;
  logic adj_prev = 1'b0;
  always @(negedge clk) begin
    if (dly_adj && dly_incdec) up_tot <= up_tot + 1;
    if (dly_adj && !dly_incdec) dn_tot <= dn_tot + 1;
    if (dly_load) load_tot <= load_tot + 1;
    if (dly_adj && adj_prev) b2b_tot <= b2b_tot + 1;
    if ((done && err) || (done2 && err2)) dual_tot <= dual_tot + 1;
    if (adj2) adj2_tot <= adj2_tot + 1;
    if (done2) done2_tot <= done2_tot + 1;
    adj_prev <= dly_adj;
  end

  typedef struct {
    int lat; bit is_err; int steps; int tap_v; int up; int dn; int loads;
  } exp_t;
  exp_t sb[$];

  task automatic set_tap(input logic [5:0] v);
    @(negedge clk); set_req = 1'b1; set_val = v;
    @(negedge clk); set_req = 1'b0;
  endtask

  // Drives one request on the main DUT and measures edges to DONE/ERR; optionally
  // pokes new requests and a new target while busy.
  task automatic run_req(input bit ld, input bit tv, input logic [5:0] tgt, input bit poke,
                         output int lat, output bit got_err, output bit timeout,
                         output bit busy_acc);
    lat = 0; got_err = 1'b0; timeout = 1'b1;
    @(negedge clk); load_req = ld; target_valid = tv; target_tap = tgt;
    @(negedge clk); load_req = 1'b0; target_valid = 1'b0; busy_acc = busy;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (poke && k == 7) begin load_req = 1'b1; target_valid = 1'b1; target_tap = 6'd63; end
      else if (poke && k == 8) begin load_req = 1'b0; target_valid = 1'b0; end
      if (done || err) begin lat = k; got_err = err; timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, err, step_count, dly_load, dly_adj, dly_incdec} !== 13'd0) begin
      failures++; $display("FAIL reset_held outputs=%h required=0",
        {busy, done, err, step_count, dly_load, dly_adj, dly_incdec});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err, step_count, dly_load, dly_adj, dly_incdec, busy2, err2, adj2} !== 16'd0) begin
        failures++; $display("FAIL reset_idle cycle=%0d outputs=%h required=0", i,
          {busy, done, err, step_count, dly_load, dly_adj, dly_incdec, busy2, err2, adj2});
      end
    end
  endtask

  // Common tail: pop one expectation and compare everything the request produced
  task automatic run_and_score(input string nm, input bit ld, input bit tv,
                               input logic [5:0] tgt, input bit poke);
    int lat, u0, d0, l0, b0, x0; bit ge, to, ba; exp_t e;
    u0 = up_tot; d0 = dn_tot; l0 = load_tot; b0 = b2b_tot; x0 = dual_tot;
    run_req(ld, tv, tgt, poke, lat, ge, to, ba);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL %s timeout no DONE/ERR within 500 cycles", nm); end
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL %s busy_after_accept got=%b required=1", nm, ba); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d required=%0d", nm, lat, e.lat); end
    checks++; if (ge !== e.is_err) begin failures++; $display("FAIL %s err got=%b required=%b", nm, ge, e.is_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_end got=%b required=0", nm, busy); end
    checks++; if (int'(step_count) != e.steps) begin failures++; $display("FAIL %s step_count got=%0d required=%0d", nm, step_count, e.steps); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b required=0", nm, done); end
    checks++; if (int'(tap) != e.tap_v) begin failures++; $display("FAIL %s tap got=%0d required=%0d", nm, tap, e.tap_v); end
    checks++; if (up_tot - u0 != e.up || dn_tot - d0 != e.dn) begin failures++;
      $display("FAIL %s pulses got up=%0d dn=%0d required up=%0d dn=%0d", nm, up_tot - u0, dn_tot - d0, e.up, e.dn); end
    checks++; if (load_tot - l0 != e.loads) begin failures++; $display("FAIL %s load_pulses got=%0d required=%0d", nm, load_tot - l0, e.loads); end
    checks++; if (b2b_tot != b0 || dual_tot != x0) begin failures++;
      $display("FAIL %s pulse_rules got b2b=%0d dual=%0d required 0 0", nm, b2b_tot - b0, dual_tot - x0); end
  endtask

  task automatic test_move_up;
    set_tap(6'd0);
    sb.push_back('{lat: 1 + 5 * (SETTLE + 2), is_err: 0, steps: 5, tap_v: 5, up: 5, dn: 0, loads: 0});
    run_and_score("move_up_busy_ignore", 1'b0, 1'b1, 6'd5, 1'b1);
  endtask

  task automatic test_move_down;
    set_tap(6'd40);
    sb.push_back('{lat: 1 + 2 * (SETTLE + 2), is_err: 0, steps: 2, tap_v: 38, up: 0, dn: 2, loads: 0});
    run_and_score("move_down", 1'b0, 1'b1, 6'd38, 1'b0);
  endtask

  task automatic test_no_move;
    set_tap(6'd12);
    sb.push_back('{lat: 1, is_err: 0, steps: 0, tap_v: 12, up: 0, dn: 0, loads: 0});
    run_and_score("no_move", 1'b0, 1'b1, 6'd12, 1'b0);
  endtask

  task automatic test_boundary;
    set_tap(6'd61);
    sb.push_back('{lat: 1 + 2 * (SETTLE + 2), is_err: 0, steps: 2, tap_v: 63, up: 2, dn: 0, loads: 0});
    run_and_score("to_63", 1'b0, 1'b1, 6'd63, 1'b0);
    set_tap(6'd1);
    sb.push_back('{lat: 1 + (SETTLE + 2), is_err: 0, steps: 1, tap_v: 0, up: 0, dn: 1, loads: 0});
    run_and_score("to_0", 1'b0, 1'b1, 6'd0, 1'b0);
  endtask

  task automatic test_load_priority;
    set_tap(6'd7);
    sb.push_back('{lat: 1 + SETTLE, is_err: 0, steps: 0, tap_v: int'(DELAY), up: 0, dn: 0, loads: 1});
    run_and_score("load_priority", 1'b1, 1'b1, 6'd50, 1'b0);
  endtask

  task automatic test_err;
    int lat, a0, dn0; bit to;
    a0 = adj2_tot; dn0 = done2_tot; lat = 0; to = 1'b1;
    @(negedge clk); t2_valid = 1'b1; t2_tap = 6'd20;
    @(negedge clk); t2_valid = 1'b0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (done2 || err2) begin lat = k; to = 1'b0; break; end
    end
    checks++; if (to || lat != 1 + 3 * (SETTLE + 2) || err2 !== 1'b1 || done2 !== 1'b0) begin failures++;
      $display("FAIL stuck_err got lat=%0d err=%b done=%b required lat=%0d err=1 done=0", lat, err2, done2, 1 + 3 * (SETTLE + 2)); end
    checks++; if (int'(step2) != 3 || busy2 !== 1'b0) begin failures++;
      $display("FAIL stuck_steps got step=%0d busy=%b required step=3 busy=0", step2, busy2); end
    repeat (3) @(negedge clk); #1;
    checks++; if (adj2_tot - a0 != 3 || done2_tot != dn0 || err2 !== 1'b1) begin failures++;
      $display("FAIL stuck_pulses got adj=%0d done=%0d err=%b required adj=3 done=0 err=1", adj2_tot - a0, done2_tot - dn0, err2); end
    @(negedge clk); t2_valid = 1'b1; t2_tap = 6'd10;
    @(negedge clk); t2_valid = 1'b0;
    checks++; if (err2 !== 1'b0 || busy2 !== 1'b1) begin failures++;
      $display("FAIL err_clear got err=%b busy=%b required err=0 busy=1", err2, busy2); end
    @(negedge clk);
    checks++; if (done2 !== 1'b1 || err2 !== 1'b0) begin failures++;
      $display("FAIL err_retry got done=%b err=%b required done=1 err=0", done2, err2); end
  endtask

  task automatic test_reset_mid;
    int u0; bit to;
    set_tap(6'd0);
    u0 = up_tot; to = 1'b1;
    @(negedge clk); target_valid = 1'b1; target_tap = 6'd5;
    @(negedge clk); target_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (up_tot - u0 >= 2) begin to = 1'b0; break; end
    end
    checks++; if (to) begin failures++; $display("FAIL reset_mid timeout waiting for pulse 2"); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, err, step_count, dly_load, dly_adj, dly_incdec} !== 13'd0) begin failures++;
      $display("FAIL reset_mid outputs=%h required=0", {busy, done, err, step_count, dly_load, dly_adj, dly_incdec}); end
    checks++; if (tap !== 6'd2) begin failures++; $display("FAIL reset_mid tap got=%0d required=2", tap); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || dly_adj !== 1'b0 || tap !== 6'd2) begin failures++;
      $display("FAIL reset_mid_after got busy=%b adj=%b tap=%0d required 0 0 2", busy, dly_adj, tap); end
  endtask

  initial begin
    test_reset;
    test_move_up;
    test_move_down;
    test_no_move;
    test_boundary;
    test_load_priority;
    test_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
